wave_nco_gen: RTL

Parametrised numerically controlled waveform generator; successor to the fixed 8-bit combinational waveform lookup tables.
- Phase accumulator with programmable tuning word drives a registered lookup producing square, triangle, sine or saw samples.
- Mode changes are glitch-free, applied at phase wrap.
- Sits between the control register block and the DAC sample interface.

---
 rtl/wave_pkg.sv | 29 ++
 rtl/wave_sine_qrom.sv | 37 +++
 rtl/wave_nco_gen.sv | 94 +++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the NCO waveform generator: mode encodings and the
// quarter-wave sine entry helper used to build ROM tables for any width.
package wave_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'b00,
    MODE_TRI    = 2'b01,
    MODE_SINE   = 2'b10,
    MODE_SAW    = 2'b11
  } mode_t;

  localparam mode_t MODE_RST = MODE_SAW;

  // round((2^(out_w-1)-1) * sin(pi*i/2^(out_w-1))); int'() rounds half away from zero.
  function automatic int qsin_entry(input int out_w, input int i);
    real x;
    real term;
    real s;
    x    = 3.14159265358979 * real'(i) / real'(1 << (out_w - 1));
    term = x;
    s    = 0.0;
    for (int n = 1; n < 20; n++) begin
      s    = s + term;
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
    end
    return int'(real'((1 << (out_w - 1)) - 1) * s);
  endfunction

endpackage

// File: rtl/wave_sine_qrom.sv
// Combinational quarter-wave sine ROM, 2^(OUT_W-2)+1 entries of
// round((H-1)*sin(pi*i/2^(OUT_W-1))); the 8-bit table is spelled out.
module wave_sine_qrom
  import wave_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W-2:0] idx,
  output logic [OUT_W-2:0] val
);

  localparam int QN = 1 << (OUT_W - 2);

  logic [OUT_W-2:0] tbl [0:QN];

  generate
    if (OUT_W == 8) begin : g_q8
      localparam int Q8 [0:64] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,  31,  34,  37,  40,  43,  46,
         49,  51,  54,  57,  60,  63,  65,  68,  71,  73,  76,  78,  81,  83,  85,  88,
         90,  92,  94,  96,  98, 100, 102, 104, 106, 107, 109, 111, 112, 113, 115, 116,
        117, 118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127,
        127
      };
      for (genvar i = 0; i <= QN; i++) begin : g_e
        assign tbl[i] = (OUT_W-1)'(Q8[i]);
      end
    end else begin : g_calc
      for (genvar i = 0; i <= QN; i++) begin : g_e
        assign tbl[i] = (OUT_W-1)'(qsin_entry(OUT_W, i));
      end
    end
  endgenerate

  assign val = tbl[idx];

endmodule

// File: rtl/wave_nco_gen.sv
// Phase-accumulator waveform generator with registered square/triangle/sine/saw lookup.
// Optional `WAVE_PHASE_OFFSET_EN adds a phase_off input added to the lookup index.
module wave_nco_gen
  import wave_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [ACC_W-1:0] tune,
  input  logic [1:0]       sel,
`ifdef WAVE_PHASE_OFFSET_EN
  input  logic [OUT_W-1:0] phase_off,
`endif
  output logic [OUT_W-1:0] wave,
  output logic             wave_valid,
  output logic             wrap,
  output logic [1:0]       mode_cur
);

  localparam logic [OUT_W-1:0] HALF    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-2:0] QUARTER = {1'b1, {(OUT_W-2){1'b0}}};

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  mode_t            mode_q;
  logic [OUT_W-1:0] idx;
  logic [OUT_W-1:0] wave_d;
  logic [OUT_W-1:0] tri_t;
  logic [OUT_W-1:0] sine_v;
  logic [OUT_W-2:0] ofs;
  logic [OUT_W-2:0] rom_idx;
  logic [OUT_W-2:0] rom_val;

`ifdef WAVE_PHASE_OFFSET_EN
  assign idx = acc[ACC_W-1 -: OUT_W] + phase_off;
`else
  assign idx = acc[ACC_W-1 -: OUT_W];
`endif

  assign sum = {1'b0, acc} + {1'b0, tune};

  // Quadrant 1/3 read the quarter table backwards; quadrants 2/3 sit below mid-scale.
  assign ofs     = {1'b0, idx[OUT_W-3:0]};
  assign rom_idx = idx[OUT_W-2] ? QUARTER - ofs : ofs;
  assign sine_v  = idx[OUT_W-1] ? HALF - {1'b0, rom_val} : HALF + {1'b0, rom_val};
  assign tri_t   = {idx[OUT_W-2:0], 1'b0};

  wave_sine_qrom #(.OUT_W(OUT_W)) u_qrom (
    .idx (rom_idx),
    .val (rom_val)
  );

  always_comb begin
    wave_d = idx;
    case (mode_q)
      MODE_SQUARE: wave_d = idx[OUT_W-1] ? '0 : '1;
      MODE_TRI:    wave_d = idx[OUT_W-1] ? ~tri_t : tri_t;
      MODE_SINE:   wave_d = sine_v;
      default:     wave_d = idx;
    endcase
  end

  // Mode only changes on clear or on accumulator carry, so samples never glitch mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      wave       <= '0;
      wave_valid <= 1'b0;
      wrap       <= 1'b0;
      mode_q     <= MODE_RST;
    end else if (sync_clr) begin
      acc        <= '0;
      wave_valid <= 1'b0;
      wrap       <= 1'b0;
      mode_q     <= mode_t'(sel);
    end else if (en) begin
      wave       <= wave_d;
      acc        <= sum[ACC_W-1:0];
      wave_valid <= 1'b1;
      wrap       <= sum[ACC_W];
      if (sum[ACC_W]) mode_q <= mode_t'(sel);
    end else begin
      wave_valid <= 1'b0;
      wrap       <= 1'b0;
    end
  end

  assign mode_cur = mode_q;

endmodule
